// File: rtl/adder_tb_pkg.sv
// adder_tb_pkg: shared definitions for the adder bench stimulus generator and
// the response checker.
//   WIDTH_DEF  : default operand width (sum is WIDTH_DEF+1 bits)
//   ERR_W_DEF  : default error-counter width
//   IDX_W      : vector index width (runs are at most 255 vectors)
//   EXP_MAX_W  : storage width of an expected sum in a pipe entry; sums of
//                narrower adders are zero-extended into it (WIDTH <= 31)
//   state_t    : checker run FSM
//   pipe_entry_t : one in-flight expectation {valid, exp, idx}
package adder_tb_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int ERR_W_DEF = 8;
    localparam int IDX_W     = 8;
    localparam int EXP_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [EXP_MAX_W-1:0] exp;
        logic [IDX_W-1:0]     idx;
    } pipe_entry_t;

endpackage

// File: rtl/resp_delay_pipe.sv
// resp_delay_pipe: STAGES-deep shift register of expectation entries. An
// entry presented at edge k appears on dout after edge k+STAGES-1, so the
// consumer compares it on edge k+STAGES.
//   clk, rst : clock, async active-high clear
//   flush    : synchronous clear of all valid bits
//   din      : entry to shift in (din.valid=0 pushes a bubble)
//   dout     : oldest entry
module resp_delay_pipe
    import adder_tb_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  pipe_entry_t din,
    output pipe_entry_t dout
);

    logic [STAGES:1]      vld_pipe;
    logic [EXP_MAX_W-1:0] exp_pipe [1:STAGES];
    logic [IDX_W-1:0]     idx_pipe [1:STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= din.valid;
            for (int s = 2; s <= STAGES; s++)
                vld_pipe[s] <= vld_pipe[s-1];
        end
    end

    // Payload only matters where the matching valid bit is set, so it
    // shifts freely and ignores flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 1; s <= STAGES; s++) begin
                exp_pipe[s] <= '0;
                idx_pipe[s] <= '0;
            end
        end else begin
            exp_pipe[1] <= din.exp;
            idx_pipe[1] <= din.idx;
            for (int s = 2; s <= STAGES; s++) begin
                exp_pipe[s] <= exp_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    always_comb begin
        dout       = '0;
        dout.valid = vld_pipe[STAGES];
        dout.exp   = exp_pipe[STAGES];
        dout.idx   = idx_pipe[STAGES];
    end

endmodule

// File: rtl/adder_resp_chk.sv
// adder_resp_chk: response checker for the adder bench. Captures each applied
// operand pair, forms the expected WIDTH+1-bit sum, delays it DUT_LAT edges
// and compares it with the DUT sum, accumulating run status over NUM_VEC
// vectors.
//   clk, rst          : clock, async active-high reset
//   start             : begin a run (honoured in IDLE and DONE only)
//   valid_in          : a_in/b_in carry an applied vector this cycle
//   a_in, b_in        : operands as driven to the DUT
//   sum_in            : DUT result {cout,sum}
//   busy, done, pass  : run status; pass = done && no mismatches
//   err_cnt           : saturating mismatch count for this run
//   first_err_*       : index, expected and observed sum of first mismatch
module adder_resp_chk
    import adder_tb_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DUT_LAT = 1,
    parameter int NUM_VEC = 16,
    parameter int ERR_W   = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH:0]   sum_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       first_err_idx,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got
);

    localparam logic [IDX_W-1:0] NV   = IDX_W'(NUM_VEC);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VEC - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] cap_cnt, chk_cnt;
    logic             push, cmp, mismatch, last_cmp, start_run;
    logic [WIDTH:0]   sum_exp, cmp_exp;
    pipe_entry_t      pipe_in, pipe_out;
    logic             unused_exp_hi;

    always_comb begin
        sum_exp       = {1'b0, a_in} + {1'b0, b_in};
        push          = (state == RUN) && valid_in && (cap_cnt < NV);
        pipe_in       = '0;
        pipe_in.valid = push;
        pipe_in.exp   = EXP_MAX_W'(sum_exp);
        pipe_in.idx   = cap_cnt;
        cmp           = (state == RUN) && pipe_out.valid;
        cmp_exp       = pipe_out.exp[WIDTH:0];
        mismatch      = cmp && (cmp_exp != sum_in);
        last_cmp      = cmp && (chk_cnt == LAST);
        start_run     = start && (state != RUN);
    end

    // Upper bits of the shared entry are zero-extension only.
    assign unused_exp_hi = ^pipe_out.exp[EXP_MAX_W-1:WIDTH+1];

    // Outside RUN nothing may reach the compare stage, so the pipe is held
    // empty; this also drops any vectors left over from an earlier run.
    resp_delay_pipe #(.STAGES(DUT_LAT)) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .flush (state != RUN),
        .din   (pipe_in),
        .dout  (pipe_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)    state_nx = RUN;
            RUN:     if (last_cmp) state_nx = DONE;
            DONE:    if (start)    state_nx = RUN;
            default:               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_cnt       <= '0;
            chk_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            done          <= 1'b0;
        end else if (start_run) begin
            cap_cnt       <= '0;
            chk_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
            done          <= 1'b0;
        end else if (state == RUN) begin
            if (push)
                cap_cnt <= cap_cnt + 1'b1;
            if (cmp)
                chk_cnt <= chk_cnt + 1'b1;
            if (mismatch) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
                if (err_cnt == '0) begin
                    first_err_idx <= pipe_out.idx;
                    first_err_exp <= cmp_exp;
                    first_err_got <= sum_in;
                end
            end
            if (last_cmp)
                done <= 1'b1;
        end
    end

    assign busy = (state == RUN);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_adder_resp_chk.sv
module tb_adder_resp_chk;

    // One run: stimulus knobs plus the status expected when it completes.
    typedef struct {
        int fault;      // u0 model corrupts vector 5 to 0x1F
        int b;          // B operand held through the run
        int mid_start;  // pulse start in the middle of the run
        int exp_pass;
        int exp_err;
        int exp_idx;
        int exp_exp;
        int exp_got;
    } run_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // u0: defaults (WIDTH=4, DUT_LAT=1, NUM_VEC=16, ERR_W=8)
    logic       st0 = 0, v0 = 0, fault0 = 0;
    logic [3:0] a0 = 0, b0 = 0;
    logic [4:0] s0 = 0;
    logic       busy0, done0, pass0;
    logic [7:0] err0, fidx0;
    logic [4:0] fexp0, fgot0;

    // u1: DUT_LAT=3
    logic       st1 = 0, v1 = 0;
    logic [3:0] a1 = 0, b1 = 0;
    logic [4:0] s1 = 0, m1a = 0, m1b = 0;
    logic       busy1, done1, pass1;
    logic [7:0] err1, fidx1;
    logic [4:0] fexp1, fgot1;

    // u2: NUM_VEC=255, ERR_W=4
    logic       st2 = 0, v2 = 0;
    logic [3:0] a2 = 0, b2 = 0;
    logic [4:0] s2 = 0;
    logic       busy2, done2, pass2;
    logic [3:0] err2;
    logic [7:0] fidx2;
    logic [4:0] fexp2, fgot2;

    int       n_chk = 0;
    int       n_pass = 0;
    run_vec_t sb_q[$];
    run_vec_t tbl[3];

    adder_resp_chk u0 (
        .clk(clk), .rst(rst), .start(st0), .valid_in(v0), .a_in(a0), .b_in(b0),
        .sum_in(s0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_idx(fidx0), .first_err_exp(fexp0), .first_err_got(fgot0)
    );

    adder_resp_chk #(.DUT_LAT(3)) u1 (
        .clk(clk), .rst(rst), .start(st1), .valid_in(v1), .a_in(a1), .b_in(b1),
        .sum_in(s1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_idx(fidx1), .first_err_exp(fexp1), .first_err_got(fgot1)
    );

    adder_resp_chk #(.NUM_VEC(255), .ERR_W(4)) u2 (
        .clk(clk), .rst(rst), .start(st2), .valid_in(v2), .a_in(a2), .b_in(b2),
        .sum_in(s2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_idx(fidx2), .first_err_exp(fexp2), .first_err_got(fgot2)
    );

    always #5 clk = ~clk;

    // Adder models feeding sum_in: 1-cycle (optionally faulty), 3-cycle, inverting.
    always @(posedge clk) begin
        s0  <= (fault0 && a0 == 4'd5) ? 5'h1F : ({1'b0, a0} + {1'b0, b0});
        m1a <= {1'b0, a1} + {1'b0, b1};
        m1b <= m1a;
        s1  <= m1b;
        s2  <= ~({1'b0, a2} + {1'b0, b2});
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " u0 outputs zero"},
            int'({busy0, done0, pass0, err0, fidx0, fexp0, fgot0}), 0);
        chk({tag, " u1 outputs zero"},
            int'({busy1, done1, pass1, err1, fidx1, fexp1, fgot1}), 0);
        chk({tag, " u2 outputs zero"},
            int'({busy2, done2, pass2, err2, fidx2, fexp2, fgot2}), 0);
    endtask

    // Pop the oldest expected run status and compare the chosen instance.
    task automatic sb_check(input int inst, input string tag);
        run_vec_t r;
        int p, e, ix, ex, gt;
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 0, 1);
            return;
        end
        r = sb_q.pop_front();
        case (inst)
            0:       begin p = int'(pass0); e = int'(err0); ix = int'(fidx0); ex = int'(fexp0); gt = int'(fgot0); end
            1:       begin p = int'(pass1); e = int'(err1); ix = int'(fidx1); ex = int'(fexp1); gt = int'(fgot1); end
            default: begin p = int'(pass2); e = int'(err2); ix = int'(fidx2); ex = int'(fexp2); gt = int'(fgot2); end
        endcase
        chk({tag, " pass"},          p,  r.exp_pass);
        chk({tag, " err_cnt"},       e,  r.exp_err);
        chk({tag, " first_err_idx"}, ix, r.exp_idx);
        chk({tag, " first_err_exp"}, ex, r.exp_exp);
        chk({tag, " first_err_got"}, gt, r.exp_got);
    endtask

    // 16-vector run on u0: A=0..15, B fixed. Last capture edge is the 16th
    // edge after start is taken; its compare lands one edge later.
    task automatic run0(input run_vec_t r, input string tag);
        fault0 = (r.fault != 0);
        sb_q.push_back(r);
        @(negedge clk) st0 = 1'b1;
        @(negedge clk) st0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v0  = 1'b1;
            a0  = 4'(i);
            b0  = 4'(r.b);
            st0 = (r.mid_start != 0 && i == 8);
            @(negedge clk);
        end
        v0  = 1'b0;
        st0 = 1'b0;
        chk({tag, " busy before last compare"}, int'(busy0), 1);
        chk({tag, " done before last compare"}, int'(done0), 0);
        @(negedge clk);
        chk({tag, " busy after last compare"}, int'(busy0), 0);
        chk({tag, " done after last compare"}, int'(done0), 1);
        sb_check(0, tag);
    endtask

    initial begin
        int sent, c;

        //            fault b mid  pass err idx exp got
        tbl[0] = '{0,   0, 0,   1,   0,  0,  0,  0};
        tbl[1] = '{1,   0, 0,   0,   1,  5,  5,  31};
        tbl[2] = '{0,   3, 1,   1,   0,  0,  0,  0};

        repeat (2) @(negedge clk);
        reset_check("por");
        rst = 1'b0;
        // valid_in is ignored in IDLE
        v0 = 1'b1; a0 = 4'd3;
        @(negedge clk);
        v0 = 1'b0;
        reset_check("idle");

        // Clean sweep, single fault at vector 5, then restart from DONE with
        // carries and a stray start pulse mid-run.
        for (int t = 0; t < 3; t++)
            run0(tbl[t], $sformatf("u0 run%0d", t));

        // Reset after 7 compares (one of them a mismatch), then a clean rerun.
        fault0 = 1'b1;
        @(negedge clk) st0 = 1'b1;
        @(negedge clk) st0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v0 = 1'b1; a0 = 4'(i); b0 = 4'd0;
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("midrun err before reset", int'(err0), 1);
        chk("midrun busy before reset", int'(busy0), 1);
        rst = 1'b1;
        #1;
        reset_check("midrun");
        @(negedge clk) rst = 1'b0;
        fault0 = 1'b0;
        @(negedge clk);
        run0(tbl[0], "u0 rerun");

        // DUT_LAT=3 with a bubble every third cycle; bubble operands are junk.
        sb_q.push_back('{0, 0, 0, 1, 0, 0, 0, 0});
        @(negedge clk) st1 = 1'b1;
        @(negedge clk) st1 = 1'b0;
        sent = 0;
        c = 0;
        while (sent < 16) begin
            if (c % 3 == 2) begin
                v1 = 1'b0; a1 = 4'hA; b1 = 4'h7;
            end else begin
                v1 = 1'b1; a1 = 4'(sent); b1 = 4'(sent);
                sent++;
            end
            c++;
            @(negedge clk);
        end
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("u1 done before last+3", int'(done1), 0);
        @(negedge clk);
        chk("u1 done at last+3", int'(done1), 1);
        chk("u1 busy at last+3", int'(busy1), 0);
        sb_check(1, "u1 lat3");

        // Inverting model over 255 vectors: 4-bit counter saturates.
        sb_q.push_back('{0, 0, 0, 0, 15, 0, 0, 31});
        @(negedge clk) st2 = 1'b1;
        @(negedge clk) st2 = 1'b0;
        for (int i = 0; i < 255; i++) begin
            v2 = 1'b1; a2 = 4'(i); b2 = 4'd0;
            @(negedge clk);
        end
        v2 = 1'b0;
        for (int k = 0; k < 10 && !done2; k++)
            @(negedge clk);
        chk("u2 done within bound", int'(done2), 1);
        sb_check(2, "u2 sat");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
